// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: FSM states, bus size/strobe codes,
// data-bus request/response bundles and the M pipeline register layout.
package memory_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } mstate_t;

   localparam logic [2:0] MSIZE4     = 3'b010;
   localparam logic [3:0] STRB_STORE = 4'b1111;
   localparam logic [3:0] STRB_LOAD  = 4'b0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbusReq_t;

   typedef struct packed {
      logic        addrOk;
      logic        dataOk;
      logic [31:0] data;
   } dbusResp_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] aluOut;
      logic [31:0] writeData;
      logic [4:0]  writeReg;
      logic        regWrite;
      logic        memtoReg;
      logic        memWrite;
   } mReg_t;

endpackage

// File: rtl/memory_stage_min.sv
// M pipeline register: stall, flush and a flush deferred until the
// in-flight memory transaction has completed.
module Min
   import memory_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        StallM,
   input  logic        FlushM,
   input  logic        busy,
   input  logic [31:0] PCE,
   input  logic [31:0] ALUOutE,
   input  logic [31:0] WriteDataE,
   input  logic [4:0]  WriteRegE,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemWriteE,
   output logic [31:0] PCM,
   output logic [31:0] ALUOutM,
   output logic [31:0] WriteDataM,
   output logic [4:0]  WriteRegM,
   output logic        RegWriteM,
   output logic        MemtoRegM,
   output logic        MemWriteM,
   output logic        advance,
   output logic        bubble
);

   mReg_t mReg;
   mReg_t eIn;
   logic  pendFlush;
   logic  flushReq;

   assign eIn.pc        = PCE;
   assign eIn.aluOut    = ALUOutE;
   assign eIn.writeData = WriteDataE;
   assign eIn.writeReg  = WriteRegE;
   assign eIn.regWrite  = RegWriteE;
   assign eIn.memtoReg  = MemtoRegE;
   assign eIn.memWrite  = MemWriteE;

   assign flushReq = FlushM | pendFlush;
   assign advance  = !busy & (flushReq | !StallM);
   assign bubble   = !busy & flushReq;

   assign PCM        = mReg.pc;
   assign ALUOutM    = mReg.aluOut;
   assign WriteDataM = mReg.writeData;
   assign WriteRegM  = mReg.writeReg;
   assign RegWriteM  = mReg.regWrite;
   assign MemtoRegM  = mReg.memtoReg;
   assign MemWriteM  = mReg.memWrite;

   // Hold while a transaction is open, remembering any flush seen meanwhile
   always_ff @(posedge clk) begin
      if (reset) begin
         mReg      <= '0;
         pendFlush <= 1'b0;
      end else if (busy) begin
         if (FlushM) pendFlush <= 1'b1;
      end else if (flushReq) begin
         mReg      <= '0;
         pendFlush <= 1'b0;
      end else if (!StallM) begin
         mReg <= eIn;
      end
   end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: M register, data-bus handshake FSM and load-data hold.
// Optional MEM_ALIGN_CHECK_EN adds misaligned-address exceptions.
module memory_stage
   import memory_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        StallM,
   input  logic        FlushM,
   input  logic [31:0] PCE,
   input  logic [31:0] ALUOutE,
   input  logic [31:0] WriteDataE,
   input  logic [4:0]  WriteRegE,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemWriteE,
   output logic [31:0] PCM,
   output logic [31:0] ALUOutM,
   output logic [4:0]  WriteRegM,
   output logic        RegWriteM,
   output logic        MemtoRegM,
   output logic [31:0] ReadDataM,
   output logic        DStallM,
   output logic        dreq_valid,
   output logic [31:0] dreq_addr,
   output logic [2:0]  dreq_size,
   output logic [3:0]  dreq_strobe,
   output logic [31:0] dreq_data,
   input  logic        dresp_addr_ok,
   input  logic        dresp_data_ok,
   input  logic [31:0] dresp_data
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic        AdELM,
   output logic        AdESM
`endif
);

   mstate_t     state;
   dbusReq_t    req;
   dbusResp_t   resp;
   logic [31:0] WriteDataM;
   logic [31:0] readHold;
   logic        MemWriteM;
   logic        memop;
   logic        alignErr;
   logic        dataAck;
   logic        advance;
   logic        bubble;

   Min uMin (
      .clk        (clk),
      .reset      (reset),
      .StallM     (StallM),
      .FlushM     (FlushM),
      .busy       (DStallM),
      .PCE        (PCE),
      .ALUOutE    (ALUOutE),
      .WriteDataE (WriteDataE),
      .WriteRegE  (WriteRegE),
      .RegWriteE  (RegWriteE),
      .MemtoRegE  (MemtoRegE),
      .MemWriteE  (MemWriteE),
      .PCM        (PCM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .WriteRegM  (WriteRegM),
      .RegWriteM  (RegWriteM),
      .MemtoRegM  (MemtoRegM),
      .MemWriteM  (MemWriteM),
      .advance    (advance),
      .bubble     (bubble)
   );

   assign memop = MemtoRegM | MemWriteM;

`ifdef MEM_ALIGN_CHECK_EN
   assign alignErr = memop & (ALUOutM[1:0] != 2'b00);
   assign AdELM    = MemtoRegM & alignErr;
   assign AdESM    = MemWriteM & alignErr;
`else
   assign alignErr = 1'b0;
`endif

   assign resp.addrOk = dresp_addr_ok;
   assign resp.dataOk = dresp_data_ok;
   assign resp.data   = dresp_data;

   assign req.valid  = ((state == IDLE) & memop & !alignErr)
                     | (state == ADDR);
   assign req.addr   = ALUOutM;
   assign req.size   = MSIZE4;
   assign req.strobe = MemWriteM ? STRB_STORE : STRB_LOAD;
   assign req.data   = WriteDataM;

   assign dreq_valid  = req.valid;
   assign dreq_addr   = req.addr;
   assign dreq_size   = req.size;
   assign dreq_strobe = req.strobe;
   assign dreq_data   = req.data;

   // data_ok only counts once the address phase has been accepted
   assign dataAck = (req.valid & resp.addrOk & resp.dataOk)
                  | ((state == DATA) & resp.dataOk);

   assign DStallM = memop & (state != DONE) & !dataAck & !alignErr;

   assign ReadDataM = dataAck ? resp.data : readHold;

   // Handshake FSM; a finished op skips DONE when M advances the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (memop) begin
                  if (alignErr | dataAck) state <= advance ? IDLE : DONE;
                  else if (resp.addrOk)   state <= DATA;
                  else                    state <= ADDR;
               end
            end
            ADDR: begin
               if (dataAck)          state <= advance ? IDLE : DONE;
               else if (resp.addrOk) state <= DATA;
            end
            DATA: begin
               if (dataAck) state <= advance ? IDLE : DONE;
            end
            DONE: begin
               if (advance) state <= IDLE;
            end
         endcase
      end
   end

   // Keep load data for W while M is stalled; drop it when M bubbles
   always_ff @(posedge clk) begin
      if (reset | bubble) readHold <= '0;
      else if (dataAck & MemtoRegM) readHold <= resp.data;
   end

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: scenario tasks plus a request scoreboard
// that matches each accepted bus request against what the bench issued.
module tb_memory_stage;

   logic        clk;
   logic        reset;
   logic        StallM;
   logic        FlushM;
   logic [31:0] PCE;
   logic [31:0] ALUOutE;
   logic [31:0] WriteDataE;
   logic [4:0]  WriteRegE;
   logic        RegWriteE;
   logic        MemtoRegE;
   logic        MemWriteE;
   logic [31:0] PCM;
   logic [31:0] ALUOutM;
   logic [4:0]  WriteRegM;
   logic        RegWriteM;
   logic        MemtoRegM;
   logic [31:0] ReadDataM;
   logic        DStallM;
   logic        dreq_valid;
   logic [31:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [3:0]  dreq_strobe;
   logic [31:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [31:0] dresp_data;
`ifdef MEM_ALIGN_CHECK_EN
   logic        AdELM;
   logic        AdESM;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
   } req_t;

   req_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   memory_stage dut (
      .clk           (clk),
      .reset         (reset),
      .StallM        (StallM),
      .FlushM        (FlushM),
      .PCE           (PCE),
      .ALUOutE       (ALUOutE),
      .WriteDataE    (WriteDataE),
      .WriteRegE     (WriteRegE),
      .RegWriteE     (RegWriteE),
      .MemtoRegE     (MemtoRegE),
      .MemWriteE     (MemWriteE),
      .PCM           (PCM),
      .ALUOutM       (ALUOutM),
      .WriteRegM     (WriteRegM),
      .RegWriteM     (RegWriteM),
      .MemtoRegM     (MemtoRegM),
      .ReadDataM     (ReadDataM),
      .DStallM       (DStallM),
      .dreq_valid    (dreq_valid),
      .dreq_addr     (dreq_addr),
      .dreq_size     (dreq_size),
      .dreq_strobe   (dreq_strobe),
      .dreq_data     (dreq_data),
      .dresp_addr_ok (dresp_addr_ok),
      .dresp_data_ok (dresp_data_ok),
      .dresp_data    (dresp_data)
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .AdELM         (AdELM),
      .AdESM         (AdESM)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scoreboard: every accepted request must match the oldest issued one
   always @(negedge clk) begin
      if (!reset && dreq_valid && dresp_addr_ok) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_req addr=%h", dreq_addr);
         end else begin
            req_t e;
            e = expQ.pop_front();
            if (dreq_addr !== e.addr || dreq_strobe !== e.strobe
                || dreq_data !== e.data || dreq_size !== 3'b010) begin
               errors++;
               $display("FAIL sb_req got %h/%b/%h/%b want %h/%b/%h/010",
                        dreq_addr, dreq_strobe, dreq_data, dreq_size,
                        e.addr, e.strobe, e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic busIdle();
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      dresp_data    = 32'h0;
   endtask

   task automatic eNop();
      PCE = '0; ALUOutE = '0; WriteDataE = '0; WriteRegE = '0;
      RegWriteE = 1'b0; MemtoRegE = 1'b0; MemWriteE = 1'b0;
   endtask

   task automatic eMem(input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] wd, input logic st);
      req_t r;
      PCE = pc; ALUOutE = a; WriteDataE = wd; WriteRegE = 5'd5;
      RegWriteE = !st; MemtoRegE = !st; MemWriteE = st;
      r.addr = a; r.strobe = st ? 4'b1111 : 4'b0000; r.data = wd;
      expQ.push_back(r);
   endtask

   task automatic test_reset();
      reset = 1'b1; StallM = 1'b0; FlushM = 1'b0;
      eNop(); busIdle();
      step(); step();
      reset = 1'b0;
      #1;
      checks++;
      if ({PCM, ALUOutM, WriteRegM, RegWriteM, MemtoRegM} !== '0) begin
         errors++;
         $display("FAIL reset_mreg got %h %h %h %b %b want 0",
                  PCM, ALUOutM, WriteRegM, RegWriteM, MemtoRegM);
      end
      checks++;
      if (dreq_valid !== 1'b0 || DStallM !== 1'b0 || ReadDataM !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus valid=%b stall=%b rd=%h want 0 0 0",
                  dreq_valid, DStallM, ReadDataM);
      end
      checks++;
      if (dreq_size !== 3'b010 || dreq_strobe !== 4'b0000) begin
         errors++;
         $display("FAIL reset_size got %b/%b want 010/0000",
                  dreq_size, dreq_strobe);
      end
   endtask

   task automatic test_single_load();
      eMem(32'h100, 32'h8000_0010, 32'h0, 1'b0);
      step();
      eNop();
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hDEADBEEF;
      #1;
      checks++;
      if (dreq_valid !== 1'b1 || DStallM !== 1'b0) begin
         errors++;
         $display("FAIL sload_issue valid=%b stall=%b want 1 0",
                  dreq_valid, DStallM);
      end
      checks++;
      if (ReadDataM !== 32'hDEADBEEF || ALUOutM !== 32'h8000_0010) begin
         errors++;
         $display("FAIL sload_data rd=%h alu=%h want deadbeef 80000010",
                  ReadDataM, ALUOutM);
      end
      step();
      busIdle();
      #1;
      checks++;
      if (dreq_valid !== 1'b0 || DStallM !== 1'b0) begin
         errors++;
         $display("FAIL sload_after valid=%b stall=%b want 0 0",
                  dreq_valid, DStallM);
      end
   endtask

   task automatic test_slow_store();
      int stalls = 0;
      int valids = 0;
      eMem(32'h104, 32'h8000_0020, 32'h1234_5678, 1'b1);
      step();
      eNop();
      for (int c = 0; c < 6; c++) begin
         dresp_addr_ok = (c == 2);
         dresp_data_ok = (c == 5);
         #1;
         if (DStallM) stalls++;
         if (dreq_valid) begin
            valids++;
            checks++;
            if (dreq_addr !== 32'h8000_0020 || dreq_data !== 32'h1234_5678
                || dreq_strobe !== 4'b1111) begin
               errors++;
               $display("FAIL sstore_fields c=%0d got %h/%h/%b", c,
                        dreq_addr, dreq_data, dreq_strobe);
            end
         end
         step();
      end
      busIdle();
      #1;
      checks++;
      if (stalls != 5 || valids != 3) begin
         errors++;
         $display("FAIL sstore_cycles stall=%0d valid=%0d want 5 3",
                  stalls, valids);
      end
      checks++;
      if (dreq_valid !== 1'b0 || expQ.size() != 0) begin
         errors++;
         $display("FAIL sstore_single valid=%b pending=%0d want 0 0",
                  dreq_valid, expQ.size());
      end
   endtask

   task automatic test_stall_after_done();
      eMem(32'h108, 32'h8000_0030, 32'h0, 1'b0);
      step();
      eNop();
      StallM = 1'b1;
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hCAFEF00D;
      #1;
      checks++;
      if (ReadDataM !== 32'hCAFEF00D || DStallM !== 1'b0) begin
         errors++;
         $display("FAIL xstall_first rd=%h stall=%b want cafef00d 0",
                  ReadDataM, DStallM);
      end
      step();
      busIdle();
      dresp_data = 32'h0BAD_0BAD;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (dreq_valid !== 1'b0 || DStallM !== 1'b0
             || ReadDataM !== 32'hCAFEF00D || MemtoRegM !== 1'b1) begin
            errors++;
            $display("FAIL xstall_hold c=%0d valid=%b stall=%b rd=%h m=%b",
                     c, dreq_valid, DStallM, ReadDataM, MemtoRegM);
         end
         step();
      end
      StallM = 1'b0;
      step();
      busIdle();
      #1;
      checks++;
      if (MemtoRegM !== 1'b0 || dreq_valid !== 1'b0) begin
         errors++;
         $display("FAIL xstall_release m=%b valid=%b want 0 0",
                  MemtoRegM, dreq_valid);
      end
   endtask

   task automatic test_flush_in_data();
      eMem(32'h10C, 32'h8000_0040, 32'h0, 1'b0);
      step();
      eNop();
      dresp_addr_ok = 1'b1;
      #1;
      checks++;
      if (DStallM !== 1'b1) begin
         errors++;
         $display("FAIL flush_addr stall=%b want 1", DStallM);
      end
      step();
      dresp_addr_ok = 1'b0;
      FlushM = 1'b1;
      #1;
      checks++;
      if (RegWriteM !== 1'b1 || DStallM !== 1'b1 || dreq_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_data rw=%b stall=%b valid=%b want 1 1 0",
                  RegWriteM, DStallM, dreq_valid);
      end
      step();
      FlushM = 1'b0;
      dresp_data_ok = 1'b1; dresp_data = 32'h55AA_55AA;
      #1;
      checks++;
      if (RegWriteM !== 1'b1 || DStallM !== 1'b0) begin
         errors++;
         $display("FAIL flush_deferred rw=%b stall=%b want 1 0",
                  RegWriteM, DStallM);
      end
      step();
      busIdle();
      #1;
      checks++;
      if (RegWriteM !== 1'b0 || MemtoRegM !== 1'b0 || ALUOutM !== 32'h0
          || ReadDataM !== 32'h0) begin
         errors++;
         $display("FAIL flush_bubble rw=%b m=%b alu=%h rd=%h want 0",
                  RegWriteM, MemtoRegM, ALUOutM, ReadDataM);
      end
   endtask

   task automatic test_reset_in_addr();
      eMem(32'h110, 32'h8000_0050, 32'h0, 1'b0);
      step();
      eNop();
      step();
      checks++;
      if (dreq_valid !== 1'b1 || DStallM !== 1'b1) begin
         errors++;
         $display("FAIL raddr_wait valid=%b stall=%b want 1 1",
                  dreq_valid, DStallM);
      end
      reset = 1'b1;
      step();
      checks++;
      if (dreq_valid !== 1'b0 || DStallM !== 1'b0 || ALUOutM !== 32'h0
          || PCM !== 32'h0 || MemtoRegM !== 1'b0 || RegWriteM !== 1'b0) begin
         errors++;
         $display("FAIL raddr_reset valid=%b stall=%b alu=%h pc=%h",
                  dreq_valid, DStallM, ALUOutM, PCM);
      end
      reset = 1'b0;
      checks++;
      if (expQ.size() != 1) begin
         errors++;
         $display("FAIL raddr_pending got %0d want 1", expQ.size());
      end
      expQ.delete();
   endtask

   task automatic test_back_to_back();
      eMem(32'h200, 32'h8000_0060, 32'h0, 1'b0);
      step();
      eMem(32'h204, 32'h8000_0064, 32'h0, 1'b0);
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h1111_1111;
      #1;
      checks++;
      if (ReadDataM !== 32'h1111_1111 || DStallM !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first rd=%h stall=%b", ReadDataM, DStallM);
      end
      step();
      eNop();
      dresp_data = 32'h2222_2222;
      #1;
      checks++;
      if (dreq_valid !== 1'b1 || dreq_addr !== 32'h8000_0064
          || ReadDataM !== 32'h2222_2222 || PCM !== 32'h204) begin
         errors++;
         $display("FAIL b2b_second valid=%b addr=%h rd=%h pc=%h",
                  dreq_valid, dreq_addr, ReadDataM, PCM);
      end
      step();
      busIdle();
   endtask

   task automatic test_non_mem();
      PCE = 32'h300; ALUOutE = 32'h0000_1234; WriteRegE = 5'd9;
      RegWriteE = 1'b1;
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
      step();
      eNop();
      #1;
      checks++;
      if (ALUOutM !== 32'h0000_1234 || WriteRegM !== 5'd9
          || dreq_valid !== 1'b0 || DStallM !== 1'b0) begin
         errors++;
         $display("FAIL nonmem alu=%h wr=%0d valid=%b stall=%b",
                  ALUOutM, WriteRegM, dreq_valid, DStallM);
      end
      step();
      busIdle();
   endtask

`ifdef MEM_ALIGN_CHECK_EN
   task automatic test_align();
      PCE = 32'h400; ALUOutE = 32'h8000_0002; MemtoRegE = 1'b1;
      RegWriteE = 1'b1;
      step();
      eNop();
      dresp_addr_ok = 1'b1;
      #1;
      checks++;
      if (AdELM !== 1'b1 || AdESM !== 1'b0 || dreq_valid !== 1'b0
          || DStallM !== 1'b0) begin
         errors++;
         $display("FAIL align adel=%b ades=%b valid=%b stall=%b",
                  AdELM, AdESM, dreq_valid, DStallM);
      end
      step();
      busIdle();
   endtask
`endif

   initial begin
      test_reset();
      test_single_load();
      test_slow_store();
      test_stall_after_done();
      test_flush_in_data();
      test_reset_in_addr();
      test_back_to_back();
      test_non_mem();
`ifdef MEM_ALIGN_CHECK_EN
      test_align();
`endif
      step();
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d want 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
